// File: rtl/ship_tracker.sv
// Single-ship tracker: run-time placement, registered hit/nearmiss/miss scoring and damage mask.
// Optional shot statistics are enabled with the SHIP_TRACKER_STATS_EN macro.
module ship_tracker #(
   parameter int COORD_W  = 4,
   parameter int GRID_MAX = 10,
   parameter int SHIP_LEN = 2
) (
   input  logic                            clock,
   input  logic                            reset_L,
   input  logic                            place,
   input  logic [COORD_W-1:0]              place_x,
   input  logic [COORD_W-1:0]              place_y,
   input  logic                            place_vert,
   input  logic                            shot_valid,
   input  logic [COORD_W-1:0]              shot_x,
   input  logic [COORD_W-1:0]              shot_y,
   output logic                            hit,
   output logic                            nearmiss,
   output logic                            miss,
   output logic                            repeat_hit,
   output logic                            place_err,
   output logic                            sunk,
`ifdef SHIP_TRACKER_STATS_EN
   output logic [7:0]                      shots_taken,
   output logic [7:0]                      first_hit_shot,
`endif
   output logic [$clog2(SHIP_LEN+1)-1:0]   hit_count
);

   localparam int CW1  = COORD_W + 1;
   localparam int HC_W = $clog2(SHIP_LEN + 1);
   localparam logic [CW1-1:0] LIMIT  = CW1'(GRID_MAX - 1);
   localparam logic [CW1-1:0] LEN_M1 = CW1'(SHIP_LEN - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_SUNK = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [COORD_W-1:0]   anchor_x_q, anchor_x_d, anchor_y_q, anchor_y_d;
   logic                 vert_q, vert_d;
   logic [SHIP_LEN-1:0]  mask_q, mask_d;
   logic [HC_W-1:0]      hit_count_q, hit_count_d;
   logic                 hit_q, hit_d, near_q, near_d, miss_q, miss_d;
   logic                 rep_q, rep_d, perr_q, perr_d;
`ifdef SHIP_TRACKER_STATS_EN
   logic [7:0]           shots_q, shots_d, first_q, first_d, shots_inc_s;
`endif

   logic [CW1-1:0]       sx_s, sy_s, cx_s, cy_s, dx_s, dy_s, far_x_s, far_y_s;
   logic [SHIP_LEN-1:0]  cell_hit_s;
   logic                 off_grid_s, adj_s, is_hit_s, is_rep_s, is_near_s, place_ok_s;

   // Score the incoming shot against every ship cell; distances are unsigned with no wrap.
   always_comb begin
      sx_s       = {1'b0, shot_x};
      sy_s       = {1'b0, shot_y};
      cx_s       = '0;
      cy_s       = '0;
      dx_s       = '0;
      dy_s       = '0;
      cell_hit_s = '0;
      adj_s      = 1'b0;
      off_grid_s = (sx_s > LIMIT) || (sy_s > LIMIT);
      for (int i = 0; i < SHIP_LEN; i++) begin
         cx_s = {1'b0, anchor_x_q} + (vert_q ? CW1'(0) : CW1'(i));
         cy_s = {1'b0, anchor_y_q} + (vert_q ? CW1'(i) : CW1'(0));
         dx_s = (sx_s >= cx_s) ? (sx_s - cx_s) : (cx_s - sx_s);
         dy_s = (sy_s >= cy_s) ? (sy_s - cy_s) : (cy_s - sy_s);
         if ((dx_s == CW1'(0)) && (dy_s == CW1'(0))) begin
            cell_hit_s[i] = 1'b1;
         end else begin
            cell_hit_s[i] = 1'b0;
         end
         if ((dx_s <= CW1'(1)) && (dy_s <= CW1'(1))) begin
            adj_s = 1'b1;
         end else begin
            adj_s = adj_s;
         end
      end
      is_hit_s  = (|cell_hit_s) && !off_grid_s;
      is_rep_s  = |(cell_hit_s & mask_q);
      is_near_s = adj_s && !is_hit_s && !off_grid_s;
      // Far cell computed one bit wider so an anchor near the top cannot wrap into range.
      far_x_s    = {1'b0, place_x} + (place_vert ? CW1'(0) : LEN_M1);
      far_y_s    = {1'b0, place_y} + (place_vert ? LEN_M1 : CW1'(0));
      place_ok_s = (far_x_s <= LIMIT) && (far_y_s <= LIMIT);
   end

`ifdef SHIP_TRACKER_STATS_EN
   assign shots_inc_s = (shots_q == 8'd255) ? 8'd255 : (shots_q + 8'd1);
`endif

   // Next-state: placement has priority over a shot in the same cycle.
   always_comb begin
      state_d     = state_q;
      anchor_x_d  = anchor_x_q;
      anchor_y_d  = anchor_y_q;
      vert_d      = vert_q;
      mask_d      = mask_q;
      hit_count_d = hit_count_q;
      hit_d       = 1'b0;
      near_d      = 1'b0;
      miss_d      = 1'b0;
      rep_d       = 1'b0;
      perr_d      = 1'b0;
`ifdef SHIP_TRACKER_STATS_EN
      shots_d     = shots_q;
      first_d     = first_q;
`endif
      if (place) begin
         if (place_ok_s) begin
            anchor_x_d  = place_x;
            anchor_y_d  = place_y;
            vert_d      = place_vert;
            mask_d      = '0;
            hit_count_d = '0;
            state_d     = S_ARMED;
`ifdef SHIP_TRACKER_STATS_EN
            shots_d     = 8'd0;
            first_d     = 8'd0;
`endif
         end else begin
            perr_d = 1'b1;
         end
      end else if (shot_valid && (state_q != S_IDLE)) begin
`ifdef SHIP_TRACKER_STATS_EN
         shots_d = shots_inc_s;
         if (is_hit_s && (first_q == 8'd0)) begin
            first_d = shots_inc_s;
         end else begin
            first_d = first_q;
         end
`endif
         if (is_hit_s) begin
            hit_d = 1'b1;
            if (is_rep_s) begin
               rep_d = 1'b1;
            end else begin
               mask_d      = mask_q | cell_hit_s;
               hit_count_d = hit_count_q + HC_W'(1);
               if (&(mask_q | cell_hit_s)) begin
                  state_d = S_SUNK;
               end else begin
                  state_d = state_q;
               end
            end
         end else if (is_near_s) begin
            near_d = 1'b1;
         end else begin
            miss_d = 1'b1;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, ship position, damage and output pulse registers.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= S_IDLE;
         anchor_x_q  <= '0;
         anchor_y_q  <= '0;
         vert_q      <= 1'b0;
         mask_q      <= '0;
         hit_count_q <= '0;
         hit_q       <= 1'b0;
         near_q      <= 1'b0;
         miss_q      <= 1'b0;
         rep_q       <= 1'b0;
         perr_q      <= 1'b0;
`ifdef SHIP_TRACKER_STATS_EN
         shots_q     <= 8'd0;
         first_q     <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         anchor_x_q  <= anchor_x_d;
         anchor_y_q  <= anchor_y_d;
         vert_q      <= vert_d;
         mask_q      <= mask_d;
         hit_count_q <= hit_count_d;
         hit_q       <= hit_d;
         near_q      <= near_d;
         miss_q      <= miss_d;
         rep_q       <= rep_d;
         perr_q      <= perr_d;
`ifdef SHIP_TRACKER_STATS_EN
         shots_q     <= shots_d;
         first_q     <= first_d;
`endif
      end
   end

   assign hit        = hit_q;
   assign nearmiss   = near_q;
   assign miss       = miss_q;
   assign repeat_hit = rep_q;
   assign place_err  = perr_q;
   assign sunk       = (state_q == S_SUNK);
   assign hit_count  = hit_count_q;
`ifdef SHIP_TRACKER_STATS_EN
   assign shots_taken    = shots_q;
   assign first_hit_shot = first_q;
`endif

endmodule

// File: tb/tb_ship_tracker.sv
// Directed scoreboard bench for ship_tracker (default parameters, SHIP_LEN=2).
module tb_ship_tracker;

   logic       clock = 1'b0;
   logic       reset_L;
   logic       place, place_vert, shot_valid;
   logic [3:0] place_x, place_y, shot_x, shot_y;
   logic       hit, nearmiss, miss, repeat_hit, place_err, sunk;
   logic [1:0] hit_count;
`ifdef SHIP_TRACKER_STATS_EN
   logic [7:0] shots_taken, first_hit_shot;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic       h;
      logic       n;
      logic       m;
      logic       r;
      logic       pe;
      logic [1:0] cnt;
      logic       s;
   } exp_t;

   exp_t sb_q[$];

   ship_tracker dut (
      .clock(clock), .reset_L(reset_L),
      .place(place), .place_x(place_x), .place_y(place_y), .place_vert(place_vert),
      .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
      .hit(hit), .nearmiss(nearmiss), .miss(miss), .repeat_hit(repeat_hit),
      .place_err(place_err), .sunk(sunk),
`ifdef SHIP_TRACKER_STATS_EN
      .shots_taken(shots_taken), .first_hit_shot(first_hit_shot),
`endif
      .hit_count(hit_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic h, n, m, r, pe, input logic [1:0] cnt, input logic s);
      exp_t e;
      e.h = h; e.n = n; e.m = m; e.r = r; e.pe = pe; e.cnt = cnt; e.s = s;
      return e;
   endfunction

   task automatic compare(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({name, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({name, ".hit"},       {31'd0, hit},        {31'd0, e.h});
         chk({name, ".nearmiss"},  {31'd0, nearmiss},   {31'd0, e.n});
         chk({name, ".miss"},      {31'd0, miss},       {31'd0, e.m});
         chk({name, ".repeat"},    {31'd0, repeat_hit}, {31'd0, e.r});
         chk({name, ".place_err"}, {31'd0, place_err},  {31'd0, e.pe});
         chk({name, ".hit_count"}, {30'd0, hit_count},  {30'd0, e.cnt});
         chk({name, ".sunk"},      {31'd0, sunk},       {31'd0, e.s});
      end
   endtask

   task automatic step(input string name, input logic pl, input int px, input int py, input logic pv,
                       input logic sv, input int sx, input int sy, input exp_t e);
      @(negedge clock);
      place      = pl;
      place_x    = 4'(px);
      place_y    = 4'(py);
      place_vert = pv;
      shot_valid = sv;
      shot_x     = 4'(sx);
      shot_y     = 4'(sy);
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      compare(name);
   endtask

   task automatic shot(input string name, input int sx, input int sy, input exp_t e);
      step(name, 1'b0, 0, 0, 1'b0, 1'b1, sx, sy, e);
   endtask

   task automatic put(input string name, input int px, input int py, input logic pv, input exp_t e);
      step(name, 1'b1, px, py, pv, 1'b0, 0, 0, e);
   endtask

   initial begin
      reset_L = 1'b0;
      place = 1'b0; place_vert = 1'b0; shot_valid = 1'b0;
      place_x = 4'd0; place_y = 4'd0; shot_x = 4'd0; shot_y = 4'd0;
      #1;
      chk("rst.hit", {31'd0, hit}, 32'd0);
      chk("rst.hit_count", {30'd0, hit_count}, 32'd0);
      chk("rst.sunk", {31'd0, sunk}, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_L = 1'b1;

      shot("idle_shot", 2, 9, mk(0, 0, 0, 0, 0, 2'd0, 0));
      step("place_with_shot", 1'b1, 2, 9, 1'b0, 1'b1, 2, 9, mk(0, 0, 0, 0, 0, 2'd0, 0));
      shot("hit_2_9", 2, 9, mk(1, 0, 0, 0, 0, 2'd1, 0));
      shot("hit_3_9", 3, 9, mk(1, 0, 0, 0, 0, 2'd2, 1));
      shot("near_4_8", 4, 8, mk(0, 1, 0, 0, 0, 2'd2, 1));
      shot("miss_0_0", 0, 0, mk(0, 0, 1, 0, 0, 2'd2, 1));
      shot("offgrid_12_3", 12, 3, mk(0, 0, 1, 0, 0, 2'd2, 1));
      shot("rep_2_9", 2, 9, mk(1, 0, 0, 1, 0, 2'd2, 1));
      put("rej_9_9_h", 9, 9, 1'b0, mk(0, 0, 0, 0, 1, 2'd2, 1));
      shot("kept_3_9", 3, 9, mk(1, 0, 0, 1, 0, 2'd2, 1));

      put("place_1_6_v", 1, 6, 1'b1, mk(0, 0, 0, 0, 0, 2'd0, 0));
      shot("hit_1_7", 1, 7, mk(1, 0, 0, 0, 0, 2'd1, 0));
      shot("near_2_8", 2, 8, mk(0, 1, 0, 0, 0, 2'd1, 0));
      shot("near_0_5", 0, 5, mk(0, 1, 0, 0, 0, 2'd1, 0));
      shot("miss_1_9", 1, 9, mk(0, 0, 1, 0, 0, 2'd1, 0));
      shot("hit_1_6", 1, 6, mk(1, 0, 0, 0, 0, 2'd2, 1));
      step("rej_with_shot", 1'b1, 4, 9, 1'b1, 1'b1, 1, 6, mk(0, 0, 0, 0, 1, 2'd2, 1));
      put("rej_10_0_h", 10, 0, 1'b0, mk(0, 0, 0, 0, 1, 2'd2, 1));
      put("rej_wrap_15_2", 15, 2, 1'b0, mk(0, 0, 0, 0, 1, 2'd2, 1));

      put("place_0_3_v", 0, 3, 1'b1, mk(0, 0, 0, 0, 0, 2'd0, 0));
      shot("nowrap_9_3", 9, 3, mk(0, 0, 1, 0, 0, 2'd0, 0));
      shot("near_1_5", 1, 5, mk(0, 1, 0, 0, 0, 2'd0, 0));
      shot("near_0_2", 0, 2, mk(0, 1, 0, 0, 0, 2'd0, 0));
      shot("offgrid_15_3", 15, 3, mk(0, 0, 1, 0, 0, 2'd0, 0));

      put("place_8_0_h", 8, 0, 1'b0, mk(0, 0, 0, 0, 0, 2'd0, 0));
      shot("near_9_1", 9, 1, mk(0, 1, 0, 0, 0, 2'd0, 0));
      shot("nowrap_0_0", 0, 0, mk(0, 0, 1, 0, 0, 2'd0, 0));
      shot("hit_9_0", 9, 0, mk(1, 0, 0, 0, 0, 2'd1, 0));
      shot("hit_8_0", 8, 0, mk(1, 0, 0, 0, 0, 2'd2, 1));

      put("place_5_5_h", 5, 5, 1'b0, mk(0, 0, 0, 0, 0, 2'd0, 0));
      shot("hit_5_5", 5, 5, mk(1, 0, 0, 0, 0, 2'd1, 0));

      // Reset asserted between edges while a shot is pending.
      @(negedge clock);
      place = 1'b0; shot_valid = 1'b1; shot_x = 4'd6; shot_y = 4'd5;
      #2;
      reset_L = 1'b0;
      #1;
      chk("midrst.hit_count", {30'd0, hit_count}, 32'd0);
      chk("midrst.sunk", {31'd0, sunk}, 32'd0);
      @(posedge clock);
      #1;
      chk("midrst.hit", {31'd0, hit}, 32'd0);
      chk("midrst.nearmiss", {31'd0, nearmiss}, 32'd0);
      chk("midrst.miss", {31'd0, miss}, 32'd0);
      @(negedge clock);
      reset_L = 1'b1;
      shot_valid = 1'b0;
      shot("post_rst_idle", 5, 5, mk(0, 0, 0, 0, 0, 2'd0, 0));

`ifdef SHIP_TRACKER_STATS_EN
      put("st_place", 0, 0, 1'b0, mk(0, 0, 0, 0, 0, 2'd0, 0));
      shot("st_miss1", 5, 5, mk(0, 0, 1, 0, 0, 2'd0, 0));
      shot("st_miss2", 5, 6, mk(0, 0, 1, 0, 0, 2'd0, 0));
      shot("st_hit", 0, 0, mk(1, 0, 0, 0, 0, 2'd1, 0));
      chk("st.shots_taken", {24'd0, shots_taken}, 32'd3);
      chk("st.first_hit_shot", {24'd0, first_hit_shot}, 32'd3);
      for (int i = 0; i < 300; i++) begin
         shot("st_sat", 7, 7, mk(0, 0, 1, 0, 0, 2'd1, 0));
      end
      chk("st.shots_sat", {24'd0, shots_taken}, 32'd255);
      chk("st.first_kept", {24'd0, first_hit_shot}, 32'd3);
      put("st_replace", 4, 4, 1'b0, mk(0, 0, 0, 0, 0, 2'd0, 0));
      chk("st.shots_clr", {24'd0, shots_taken}, 32'd0);
      chk("st.first_clr", {24'd0, first_hit_shot}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
